uart_tx_serializer: RTL



---
 rtl/uart_pkg.sv | 46 ++++
 rtl/uart_tx_serializer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_pkg                                                     |
// | Description : Shared UART definitions: TSR state encoding, LCR bit         |
// |               positions, default baud oversampling and a parity helper.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package uart_pkg;

    // Baud ticks per bit period (16x oversampling, as in a 16550).
    localparam int UART_TICKS_PER_BIT = 16;

    // LCR bit positions.
    localparam int LCR_WLS_LSB = 0;
    localparam int LCR_STB     = 2;
    localparam int LCR_PEN     = 3;
    localparam int LCR_EPS     = 4;
    localparam int LCR_STICK   = 5;
    localparam int LCR_BRK     = 6;

    // Transmit shift register states, explicit 3-bit encoding.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } uart_state_e;

    // Parity bit for a byte; bits above the word length do not contribute.
    function automatic logic tx_parity(input logic [7:0] data,
                                       input logic [1:0] wls,
                                       input logic       eps,
                                       input logic       stick);
        logic [7:0] mask;
        mask = 8'hFF >> (2'd3 - wls);
        if (stick) begin
            return !eps;
        end
        return eps ? (^(data & mask)) : (~^(data & mask));
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_tx_serializer                                           |
// | Description : 16550-style transmit shift register. Pops bytes from the TX  |
// |               FIFO and serializes start/data/[parity]/stop frames onto     |
// |               o_txd using an external 16x baud tick.                       |
// |               Build option UART_TX_PARITY_EN: when defined, adds the       |
// |               PARITY state and pen/eps/stick decoding; when undefined,     |
// |               lcr[5:3] are ignored and frames are start+data+stop.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,                  // only 8 is supported
    parameter int TICKS_PER_BIT = UART_TICKS_PER_BIT  // even, >= 4
) (
    input  logic                  i_sys_clk,
    input  logic                  i_sys_rst,
    input  logic                  i_baud_tick,
    input  logic [6:0]            i_lcr,
    input  logic                  i_fifo_empty,
    input  logic [DATA_WIDTH-1:0] i_fifo_rdata,
    output logic                  o_fifo_rden,
    output logic                  o_txd,
    output logic                  o_busy,
    output logic                  o_temt
);

    // Tick counter must reach 2 bit periods - 1 for two stop bits.
    localparam int                  c_TICK_W      = $clog2(2 * TICKS_PER_BIT);
    localparam logic [c_TICK_W-1:0] c_TICK_ONE    = {{(c_TICK_W-1){1'b0}}, 1'b1};
    localparam logic [c_TICK_W-1:0] c_LAST_1BIT   = c_TICK_W'(TICKS_PER_BIT - 1);
    localparam logic [c_TICK_W-1:0] c_LAST_1P5BIT = c_TICK_W'((3 * TICKS_PER_BIT) / 2 - 1);
    localparam logic [c_TICK_W-1:0] c_LAST_2BIT   = c_TICK_W'(2 * TICKS_PER_BIT - 1);

    uart_state_e           r_state_q, w_state_d;
    logic [c_TICK_W-1:0]   r_tick_q,  w_tick_d;
    logic [2:0]            r_bit_q,   w_bit_d;
    logic [DATA_WIDTH-1:0] r_shift_q, w_shift_d;
    logic [1:0]            r_wls_q;
    logic                  r_stb_q;
    logic                  r_txd_q,   w_txd_d;
    logic                  r_rden_q,  w_rden_d;

    logic                  w_in_frame;
    logic                  w_bit_end;
    logic [c_TICK_W-1:0]   w_tick_last;
    logic [2:0]            w_last_idx;

`ifdef UART_TX_PARITY_EN
    logic                  r_pen_q;
    logic                  r_par_q;
`else
    logic                  w_unused_lcr;
    assign w_unused_lcr = ^{i_lcr[LCR_STICK], i_lcr[LCR_EPS], i_lcr[LCR_PEN]};
`endif

    // Baud ticks only count while a bit is on the line.
    assign w_in_frame = (r_state_q == START) || (r_state_q == DATA) ||
                        (r_state_q == PARITY) || (r_state_q == STOP);
    assign w_last_idx = 3'd4 + {1'b0, r_wls_q};
    assign w_bit_end  = w_in_frame && i_baud_tick && (r_tick_q == w_tick_last);

    // Length of the current bit: only the stop bit can be stretched.
    always_comb begin
        w_tick_last = c_LAST_1BIT;
        if ((r_state_q == STOP) && r_stb_q) begin
            w_tick_last = (r_wls_q == 2'b00) ? c_LAST_1P5BIT : c_LAST_2BIT;
        end
    end

    // State register.
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            r_state_q <= IDLE;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    // Next-state and datapath-next logic.
    always_comb begin
        w_state_d = r_state_q;
        w_tick_d  = r_tick_q;
        w_bit_d   = r_bit_q;
        w_shift_d = r_shift_q;
        if (w_in_frame && i_baud_tick) begin
            w_tick_d = w_bit_end ? '0 : (r_tick_q + c_TICK_ONE);
        end
        case (r_state_q)
            IDLE: begin
                if (!i_fifo_empty) begin
                    w_state_d = FETCH;
                end
            end
            FETCH: begin
                w_state_d = LOAD;
            end
            LOAD: begin
                w_state_d = START;
                w_shift_d = i_fifo_rdata;
                w_tick_d  = '0;
                w_bit_d   = '0;
            end
            START: begin
                if (w_bit_end) begin
                    w_state_d = DATA;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    if (r_bit_q == w_last_idx) begin
`ifdef UART_TX_PARITY_EN
                        w_state_d = r_pen_q ? PARITY : STOP;
`else
                        w_state_d = STOP;
`endif
                    end else begin
                        w_bit_d   = r_bit_q + 3'd1;
                        w_shift_d = r_shift_q >> 1;
                    end
                end
            end
            PARITY: begin
                if (w_bit_end) begin
                    w_state_d = STOP;
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    w_state_d = i_fifo_empty ? IDLE : FETCH;
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    // Output decode from the next state so the output registers line up with the state.
    always_comb begin
        w_rden_d = (w_state_d == FETCH);
        case (w_state_d)
            START:   w_txd_d = 1'b0;
            DATA:    w_txd_d = w_shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  w_txd_d = r_par_q;
`endif
            default: w_txd_d = 1'b1;
        endcase
    end

    // Output registers; reset forces the line idle and suppresses any pending read.
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            r_txd_q  <= 1'b1;
            r_rden_q <= 1'b0;
        end else begin
            r_txd_q  <= w_txd_d;
            r_rden_q <= w_rden_d;
        end
    end

    // Tick/bit counters, shift register, and frame format latched at LOAD.
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            r_tick_q  <= '0;
            r_bit_q   <= '0;
            r_shift_q <= '0;
            r_wls_q   <= 2'b00;
            r_stb_q   <= 1'b0;
        end else begin
            r_tick_q  <= w_tick_d;
            r_bit_q   <= w_bit_d;
            r_shift_q <= w_shift_d;
            if (r_state_q == LOAD) begin
                r_wls_q <= i_lcr[LCR_WLS_LSB +: 2];
                r_stb_q <= i_lcr[LCR_STB];
            end
        end
    end

`ifdef UART_TX_PARITY_EN
    // Parity enable and the parity bit itself are fixed for the whole frame at LOAD.
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            r_pen_q <= 1'b0;
            r_par_q <= 1'b0;
        end else if (r_state_q == LOAD) begin
            r_pen_q <= i_lcr[LCR_PEN];
            r_par_q <= tx_parity(i_fifo_rdata, i_lcr[LCR_WLS_LSB +: 2],
                                 i_lcr[LCR_EPS], i_lcr[LCR_STICK]);
        end
    end
`endif

    // Break overrides the registered line level using the live LCR.
    assign o_txd       = r_txd_q & ~i_lcr[LCR_BRK];
    assign o_fifo_rden = r_rden_q;
    assign o_busy      = (r_state_q != IDLE);
    assign o_temt      = i_fifo_empty && (r_state_q == IDLE);

endmodule
`default_nettype wire
